timestamp_capture_mc: RTL and testbench

Multi-channel timestamp unit with a programmable-increment free-running time counter. CH_NUM asynchronous event inputs are synchronised and edge-detected per channel under a per-channel edge mode. Each event is tagged with counter value, channel and edge polarity, then queued in a first-word-fall-through (FWFT) capture FIFO for the frame-format or register logic. It also keeps the software-load snapshot register.

---
 rtl/timestamp_capture_mc.sv | 172 +++++++++++++++++
 tb/tb_timestamp_capture_mc.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_capture_mc.sv
// Multi-channel event timestamp unit.
// A free-running counter advances by a programmable increment each cycle.
// Each channel input is synchronised and edge-detected according to its edge mode.
// A detected edge is held in that channel's pending slot until it can be written
// to a first-word-fall-through (FWFT) capture FIFO.
// A separate snapshot register captures the counter when software requests it.
module timestamp_capture_mc #(
  parameter int TS_WD       = 64,
  parameter int CH_NUM      = 4,
  parameter int CH_WD       = 2,
  parameter int INC_WD      = 8,
  parameter int INC_DEFAULT = 25,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_AW     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH_NUM-1:0]     iv_ch_in,
  input  logic [2*CH_NUM-1:0]   iv_edge_mode,
  input  logic [INC_WD-1:0]     iv_inc,
  input  logic                  i_inc_load,
  input  logic                  i_ts_set,
  input  logic [TS_WD-1:0]      iv_ts_set_val,
  input  logic                  i_timestamp_load,
  output logic [TS_WD-1:0]      ov_timestamp_reg,
  output logic                  o_cap_valid,
  output logic [TS_WD-1:0]      ov_cap_ts,
  output logic [CH_WD-1:0]      ov_cap_ch,
  output logic                  o_cap_edge,
  input  logic                  i_cap_ready,
  output logic [FIFO_AW:0]      ov_cap_level,
  output logic                  o_overflow,
  input  logic                  i_overflow_clr
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FIFO_DEPTH = (FIFO_AW + 1)'(DEPTH);

  logic [TS_WD-1:0]   ts_cnt;
  logic [INC_WD-1:0]  inc_reg;
  logic [CH_NUM-1:0]  sync_q [SYNC_STAGES];
  logic [CH_NUM-1:0]  sync_lvl, prev_q, rise, fall, evt;
  logic [CH_NUM-1:0]  pend_vld, pend_edge, grant, ovf_hit;
  logic [TS_WD-1:0]   pend_ts [CH_NUM];
  logic               wr_any, wr_en, pop;
  logic [CH_WD-1:0]   wr_sel;
  logic [TS_WD-1:0]   mem_ts [DEPTH];
  logic [CH_WD-1:0]   mem_ch [DEPTH];
  logic [DEPTH-1:0]   mem_edge;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;

  // Time counter: a preset takes priority over the increment; the sum wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else if (i_ts_set) ts_cnt <= iv_ts_set_val;
    else ts_cnt <= ts_cnt + TS_WD'(inc_reg);
  end

  // Increment register; a loaded value is first used on the following edge.
  always_ff @(posedge clk) begin
    if (reset) inc_reg <= INC_WD'(INC_DEFAULT);
    else if (i_inc_load) inc_reg <= iv_inc;
  end

  // Snapshot register: captures the counter value from before this edge's update.
  always_ff @(posedge clk) begin
    if (reset) ov_timestamp_reg <= '0;
    else if (i_timestamp_load) ov_timestamp_reg <= ts_cnt;
  end

  // Synchroniser chain plus previous-level register for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= iv_ch_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_lvl;
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~prev_q;
  assign fall     = ~sync_lvl & prev_q;

  // Qualify each edge with that channel's live edge mode.
  always_comb begin
    evt = '0;
    for (int i = 0; i < CH_NUM; i++)
      evt[i] = (rise[i] & iv_edge_mode[2*i]) | (fall[i] & iv_edge_mode[2*i+1]);
  end

  // Fixed priority: the lowest-index pending channel gets the single write slot.
  // A same-cycle pop does not create room for this cycle's write.
  always_comb begin
    wr_any = 1'b0;
    wr_sel = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (pend_vld[i]) begin
        wr_any = 1'b1;
        wr_sel = CH_WD'(i);
      end
    end
    wr_en = wr_any && (level < FIFO_DEPTH);
    grant = '0;
    if (wr_en) grant[wr_sel] = 1'b1;
    ovf_hit = evt & pend_vld & ~grant;
  end

  // Pending slots: a new event may reuse a slot that is being drained in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld  <= '0;
      pend_edge <= '0;
      for (int i = 0; i < CH_NUM; i++) pend_ts[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (evt[i] && (!pend_vld[i] || grant[i])) begin
          pend_vld[i]  <= 1'b1;
          pend_ts[i]   <= ts_cnt;
          pend_edge[i] <= rise[i];
        end else if (grant[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flag; a new loss beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) o_overflow <= 1'b0;
    else if (|ovf_hit) o_overflow <= 1'b1;
    else if (i_overflow_clr) o_overflow <= 1'b0;
  end

  // FIFO storage; the contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_ts[wr_ptr]   <= pend_ts[wr_sel];
      mem_ch[wr_ptr]   <= wr_sel;
      mem_edge[wr_ptr] <= pend_edge[wr_sel];
    end
  end

  assign pop = o_cap_valid & i_cap_ready;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign o_cap_valid  = (level != '0);
  assign ov_cap_level = level;
  assign ov_cap_ts    = o_cap_valid ? mem_ts[rd_ptr] : '0;
  assign ov_cap_ch    = o_cap_valid ? mem_ch[rd_ptr] : '0;
  assign o_cap_edge   = o_cap_valid & mem_edge[rd_ptr];

endmodule

// File: tb/tb_timestamp_capture_mc.sv
// Directed bench for timestamp_capture_mc.
// A vector table covers the counter, the increment register and the snapshot register.
// Hand-written sequences cover edge capture, arbitration, FIFO overflow and mid-run reset.
module tb_timestamp_capture_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_in;
  logic [7:0]  edge_mode;
  logic [7:0]  inc;
  logic        inc_load;
  logic        ts_set;
  logic [63:0] set_val;
  logic        ts_load;
  logic [63:0] snap;
  logic        cap_valid;
  logic [63:0] cap_ts;
  logic [1:0]  cap_ch;
  logic        cap_edge;
  logic        cap_ready;
  logic [3:0]  cap_level;
  logic        overflow;
  logic        ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference counter model, stepped once per clock edge.
  logic [63:0] m_cnt;
  logic [7:0]  m_inc;

  timestamp_capture_mc dut (
    .clk              (clk),
    .reset            (reset),
    .iv_ch_in         (ch_in),
    .iv_edge_mode     (edge_mode),
    .iv_inc           (inc),
    .i_inc_load       (inc_load),
    .i_ts_set         (ts_set),
    .iv_ts_set_val    (set_val),
    .i_timestamp_load (ts_load),
    .ov_timestamp_reg (snap),
    .o_cap_valid      (cap_valid),
    .ov_cap_ts        (cap_ts),
    .ov_cap_ch        (cap_ch),
    .o_cap_edge       (cap_edge),
    .i_cap_ready      (cap_ready),
    .ov_cap_level     (cap_level),
    .o_overflow       (overflow),
    .i_overflow_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        inc_load;
    logic [7:0]  inc;
    logic        ts_set;
    logic [63:0] set_val;
    logic        ts_load;
    logic [63:0] exp_snap;
  } vec_t;

  vec_t vecs [18];

  task automatic tick();
    logic [63:0] nc;
    logic [7:0]  ni;
    if (reset) begin
      nc = 64'd0;
      ni = 8'd25;
    end else begin
      nc = ts_set ? set_val : m_cnt + 64'(m_inc);
      ni = inc_load ? inc : m_inc;
    end
    @(posedge clk);
    m_cnt = nc;
    m_inc = ni;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rise on ch1 held two cycles then low two cycles; returns the expected captured ts.
  task automatic pulse_ch1(output logic [63:0] ets);
    ch_in[1] = 1'b1;
    tick();
    tick();
    ets = m_cnt;
    ch_in[1] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] e1, e2, dummy;
    logic [63:0] q [9];

    // counter / increment / snapshot vectors, starting from counter = 0 after reset
    vecs[0]  = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b0, 64'd0};
    vecs[1]  = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b0, 64'd0};
    vecs[2]  = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b0, 64'd0};
    vecs[3]  = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b0, 64'd0};
    vecs[4]  = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'd100};
    vecs[5]  = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'd125};
    vecs[6]  = '{1'b1, 8'd10, 1'b0, 64'd0, 1'b1, 64'd150};
    vecs[7]  = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'd175};
    vecs[8]  = '{1'b0, 8'd0,  1'b1, 64'h1000, 1'b1, 64'd185};
    vecs[9]  = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'h1000};
    vecs[10] = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'h100A};
    vecs[11] = '{1'b1, 8'd0,  1'b0, 64'd0, 1'b1, 64'h1014};
    vecs[12] = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'h101E};
    vecs[13] = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'h101E};
    vecs[14] = '{1'b1, 8'd25, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h101E};
    vecs[15] = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0};
    vecs[16] = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0};
    vecs[17] = '{1'b0, 8'd0,  1'b0, 64'd0, 1'b1, 64'h22};

    reset = 1'b1;
    ch_in = '0;
    edge_mode = '0;
    inc = '0;
    inc_load = 1'b0;
    ts_set = 1'b0;
    set_val = '0;
    ts_load = 1'b0;
    cap_ready = 1'b0;
    ovf_clr = 1'b0;
    m_cnt = '0;
    m_inc = 8'd25;
    ticks(3);
    chk("rst_level", 64'(cap_level), 64'd0);
    chk("rst_valid", 64'(cap_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_snap", snap, 64'd0);
    chk("rst_cap_ts", cap_ts, 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      inc_load = vecs[i].inc_load;
      inc      = vecs[i].inc;
      ts_set   = vecs[i].ts_set;
      set_val  = vecs[i].set_val;
      ts_load  = vecs[i].ts_load;
      tick();
      chk($sformatf("vec%0d_snap", i), snap, vecs[i].exp_snap);
    end
    inc_load = 1'b0;
    ts_set = 1'b0;
    ts_load = 1'b0;

    // single rise on ch0, rise-only mode
    ts_set = 1'b1;
    set_val = 64'd1000;
    tick();
    ts_set = 1'b0;
    edge_mode = 8'b0000_0001;
    ch_in[0] = 1'b1;
    tick();
    tick();
    e1 = m_cnt;
    chk("t2_valid_e1", 64'(cap_valid), 64'd0);
    tick();
    chk("t2_valid_e2", 64'(cap_valid), 64'd0);
    tick();
    chk("t2_valid_e3", 64'(cap_valid), 64'd1);
    chk("t2_ch", 64'(cap_ch), 64'd0);
    chk("t2_edge", 64'(cap_edge), 64'd1);
    chk("t2_ts", cap_ts, e1);
    chk("t2_level", 64'(cap_level), 64'd1);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    chk("t2_pop_level", 64'(cap_level), 64'd0);
    ch_in[0] = 1'b0;
    ticks(5);
    chk("t2_fall_ignored", 64'(cap_valid), 64'd0);

    // both-edge mode gives a rise entry and a fall entry
    edge_mode = 8'b0000_0011;
    ch_in[0] = 1'b1;
    tick();
    tick();
    e1 = m_cnt;
    tick();
    tick();
    ch_in[0] = 1'b0;
    tick();
    tick();
    e2 = m_cnt;
    ticks(3);
    chk("t2b_level", 64'(cap_level), 64'd2);
    chk("t2b_edge0", 64'(cap_edge), 64'd1);
    chk("t2b_ts0", cap_ts, e1);
    cap_ready = 1'b1;
    tick();
    chk("t2b_edge1", 64'(cap_edge), 64'd0);
    chk("t2b_ts1", cap_ts, e2);
    chk("t2b_ch1", 64'(cap_ch), 64'd0);
    tick();
    cap_ready = 1'b0;
    chk("t2b_empty", 64'(cap_valid), 64'd0);

    // all four channels rise together: written in channel order with identical ts
    edge_mode = 8'b0101_0101;
    ch_in = 4'hF;
    tick();
    tick();
    e1 = m_cnt;
    tick();
    tick();
    chk("t3_level1", 64'(cap_level), 64'd1);
    ticks(3);
    chk("t3_level4", 64'(cap_level), 64'd4);
    cap_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_ch%0d", k), 64'(cap_ch), 64'(k));
      chk($sformatf("t3_ts%0d", k), cap_ts, e1);
      chk($sformatf("t3_edge%0d", k), 64'(cap_edge), 64'd1);
      tick();
    end
    cap_ready = 1'b0;
    chk("t3_drained", 64'(cap_level), 64'd0);
    ch_in = '0;
    ticks(4);
    chk("t3_no_fall", 64'(cap_valid), 64'd0);

    // fill the FIFO from ch1, hold one pending, then lose one
    edge_mode = 8'b0000_0100;
    for (int k = 0; k < 9; k++) pulse_ch1(q[k]);
    chk("t5_level_full", 64'(cap_level), 64'd8);
    chk("t5_no_ovf_yet", 64'(overflow), 64'd0);
    ovf_clr = 1'b1;
    ch_in[1] = 1'b1;
    tick();
    tick();
    dummy = m_cnt;
    tick();
    chk("t5_set_beats_clr", 64'(overflow), 64'd1);
    ovf_clr = 1'b0;
    ch_in[1] = 1'b0;
    tick();
    chk("t5_ovf_sticky", 64'(overflow), 64'd1);
    chk("t5_head0", cap_ts, q[0]);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    chk("t5_level_after_pop", 64'(cap_level), 64'd7);
    tick();
    chk("t5_pending_entered", 64'(cap_level), 64'd8);
    cap_ready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      chk($sformatf("t5_head%0d", k), cap_ts, q[k]);
      tick();
    end
    cap_ready = 1'b0;
    chk("t5_empty", 64'(cap_valid), 64'd0);
    chk("t5_dropped_ts_differs", 64'(dummy > q[8]), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_ovf_cleared", 64'(overflow), 64'd0);

    // reset with level 5 and a pending entry discards everything
    pulse_ch1(dummy);
    pulse_ch1(dummy);
    edge_mode = 8'b0101_0101;
    ch_in = 4'hF;
    tick();
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("t6_level5", 64'(cap_level), 64'd5);
    reset = 1'b1;
    ch_in = '0;
    tick();
    chk("t6_level", 64'(cap_level), 64'd0);
    chk("t6_valid", 64'(cap_valid), 64'd0);
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_snap", snap, 64'd0);
    chk("t6_cap_ts", cap_ts, 64'd0);
    reset = 1'b0;
    ts_load = 1'b1;
    tick();
    chk("t6_cnt0", snap, 64'd0);
    tick();
    chk("t6_inc_default", snap, 64'd25);
    ts_load = 1'b0;
    ticks(5);
    chk("t6_pending_gone", 64'(cap_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
